// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the BLE UART transmit arbiter.
// Response byte values are the command path's done/in-progress codes.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        TLM_H,
        TLM_M,
        TLM_L
    } arb_state_e;

    localparam logic [7:0] RESP_DONE      = 8'hA5;
    localparam logic [7:0] RESP_BUSY      = 8'h5A;
    localparam logic [7:0] TLM_HDR_DEF    = 8'hC3;
    localparam logic [3:0] STARVE_MAX_DEF = 4'd4;

    function automatic logic [3:0] sat_add4(input logic [3:0] cnt, input logic [1:0] inc);
        logic [4:0] sum;
        sum = {1'b0, cnt} + {3'b000, inc};
        return (sum > 5'd15) ? 4'hF : sum[3:0];
    endfunction

endpackage

// File: rtl/arb_hold_reg.sv
// Single-entry holding register with valid bit.
// drop_o flags a load that replaces an entry which was never granted.
module arb_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         grant_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // A load in the grant cycle becomes the next pending entry rather than a drop.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (grant_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign drop_o  = load_i & valid_q & ~grant_i;

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates the BLE UART transmitter between command responses and
// 3-byte heading telemetry frames, with a starvation bound for telemetry.
//
// state | meaning
// IDLE  | nothing in flight; grant decided combinationally from valid bits
// RESP  | response byte in flight, waiting for tx_done
// TLM_H | frame header in flight
// TLM_M | heading[15:8] in flight (trmt on the first cycle)
// TLM_L | heading[7:0] in flight (trmt on the first cycle)
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter logic [7:0] TLM_HDR    = TLM_HDR_DEF,
    parameter logic [3:0] STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        send_resp_i,
    input  logic [7:0]  resp_i,
    input  logic        tlm_req_i,
    input  logic [15:0] tlm_data_i,
    input  logic        tx_done_i,
    output logic        trmt_o,
    output logic [7:0]  tx_data_o,
    output logic        resp_sent_o,
    output logic        tlm_sent_o,
    output logic        busy_o,
    output logic [3:0]  drop_cnt_o
);

    arb_state_e  state_q, state_d;
    logic        next_q, next_d;
    logic [3:0]  starve_q, starve_d;
    logic [3:0]  drop_cnt_q, drop_cnt_d;
    logic [7:0]  resp_sh_q;
    logic [15:0] tlm_sh_q;

    logic        resp_v, tlm_v, resp_drop, tlm_drop;
    logic [7:0]  resp_hold;
    logic [15:0] tlm_hold;
    logic        grant_resp, grant_tlm, done_acc;

    arb_hold_reg #(.W(8)) u_resp_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (send_resp_i),
        .data_i  (resp_i),
        .grant_i (grant_resp),
        .valid_o (resp_v),
        .data_o  (resp_hold),
        .drop_o  (resp_drop)
    );

    arb_hold_reg #(.W(16)) u_tlm_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (tlm_req_i),
        .data_i  (tlm_data_i),
        .grant_i (grant_tlm),
        .valid_o (tlm_v),
        .data_o  (tlm_hold),
        .drop_o  (tlm_drop)
    );

    always_comb begin
        grant_resp = 1'b0;
        grant_tlm  = 1'b0;
        if (state_q == IDLE) begin
            if (resp_v && (!tlm_v || (starve_q < STARVE_MAX))) begin
                grant_resp = 1'b1;
            end else if (tlm_v) begin
                grant_tlm = 1'b1;
            end
        end
    end

    // next_q marks the trmt cycle of a mid-frame byte; tx_done there is stale.
    assign done_acc = tx_done_i && (state_q != IDLE) && !next_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            next_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
        end
    end

    always_comb begin
        state_d = state_q;
        next_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_resp)     state_d = RESP;
                else if (grant_tlm) state_d = TLM_H;
            end
            RESP:  if (done_acc) state_d = IDLE;
            TLM_H: if (done_acc) begin
                state_d = TLM_M;
                next_d  = 1'b1;
            end
            TLM_M: if (done_acc) begin
                state_d = TLM_L;
                next_d  = 1'b1;
            end
            TLM_L: if (done_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trmt_o      = 1'b0;
        tx_data_o   = 8'h00;
        resp_sent_o = 1'b0;
        tlm_sent_o  = 1'b0;
        case (state_q)
            IDLE: begin
                trmt_o = grant_resp | grant_tlm;
                if (grant_resp)     tx_data_o = resp_hold;
                else if (grant_tlm) tx_data_o = TLM_HDR;
            end
            RESP: begin
                tx_data_o   = resp_sh_q;
                resp_sent_o = done_acc;
            end
            TLM_H: tx_data_o = TLM_HDR;
            TLM_M: begin
                trmt_o    = next_q;
                tx_data_o = tlm_sh_q[15:8];
            end
            TLM_L: begin
                trmt_o     = next_q;
                tx_data_o  = tlm_sh_q[7:0];
                tlm_sent_o = done_acc;
            end
            default: tx_data_o = 8'h00;
        endcase
    end

    // Starve count only survives while telemetry is pending and losing.
    always_comb begin
        starve_d = starve_q;
        if (!tlm_v || grant_tlm) starve_d = 4'd0;
        else if (grant_resp)     starve_d = starve_q + 4'd1;
        drop_cnt_d = sat_add4(drop_cnt_q, {1'b0, resp_drop} + {1'b0, tlm_drop});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q   <= 4'd0;
            drop_cnt_q <= 4'd0;
            resp_sh_q  <= 8'h00;
            tlm_sh_q   <= 16'h0000;
        end else begin
            starve_q   <= starve_d;
            drop_cnt_q <= drop_cnt_d;
            if (grant_resp) resp_sh_q <= resp_hold;
            if (grant_tlm)  tlm_sh_q  <= tlm_hold;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Arbitrates the single BLE UART transmitter between two requesters:
  - Command-response bytes: 0xA5 (done) / 0x5A (in progress), from the command path.
  - 3-byte heading telemetry frames: header, heading[15:8], heading[7:0].
- Sits between the command/tour logic and the UART wrapper's trmt/tx_data/tx_done interface.
- Responses have priority, but a starvation limit guarantees telemetry forward progress.
- A telemetry frame is atomic once its first byte is issued.

Parameters:
- TLM_HDR, 8'hC3: header byte that starts every telemetry frame.
- STARVE_MAX, 4: consecutive response grants allowed while telemetry is pending; the next grant then goes to telemetry (range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- send_resp  in  1  pulse: queue response byte resp.
- resp  in  8  response byte, sampled when send_resp=1.
- tlm_req  in  1  pulse: queue telemetry frame.
- tlm_data  in  16  heading word, sampled when tlm_req=1.
- tx_done  in  1  pulse from UART: current byte fully shifted out.
- trmt  out  1  one-cycle pulse: start transmitting tx_data.
- tx_data  out  8  byte to UART; held stable from the trmt cycle through tx_done.
- resp_sent  out  1  one-cycle pulse on tx_done of a response byte.
- tlm_sent  out  1  one-cycle pulse on tx_done of a frame's last byte.
- busy  out  1  high whenever not in IDLE.
- drop_cnt  out  4  saturating count of overwritten pending entries (both sources).

Behaviour:
- Reset (rst sampled high at a clk edge) returns the block to:
  - all outputs 0; tx_data=8'h00;
  - both holding registers empty; starve counter 0; state IDLE.
- Reset mid-transmission abandons the frame immediately. No sent pulse is produced.
- Holding registers: one entry each, resp_hold (8b) and tlm_hold (16b), each with a valid bit.
  - send_resp loads resp_hold and sets resp_v.
  - If resp_v is already set and that entry has not yet been granted, the new byte overwrites it and drop_cnt increments (saturates at 15).
  - tlm_req behaves the same way on tlm_hold.
  - Once granted, an entry is copied to the transmit shadow and its valid bit clears in the same cycle, so a new request can be accepted immediately.
- A request arriving in the same cycle as its own grant is captured as a new pending entry. It is not dropped.
- FSM states: IDLE, RESP, TLM_H, TLM_M, TLM_L.
- IDLE grant decision (evaluated on registered valid bits):
  - resp_v only -> grant response.
  - tlm_v only -> grant telemetry.
  - Both set, starve counter < STARVE_MAX -> grant response and increment the counter.
  - Both set, starve counter = STARVE_MAX -> grant telemetry.
  - Every telemetry grant, and every cycle in which tlm_v=0, clears the starve counter.
- Granting a source:
  - Moves the FSM to RESP or TLM_H.
  - Pulses trmt for exactly one cycle.
  - Drives tx_data with resp_hold or TLM_HDR, valid in that same cycle.
- Latency: send_resp in cycle N with the block IDLE and tlm_v=0 -> trmt high in cycle N+1.
- RESP: wait for tx_done, then pulse resp_sent and return to IDLE. The next grant is evaluated on the following cycle, so there is at least one idle cycle between bytes.
- TLM_H --tx_done--> TLM_M: pulse trmt with tx_data=tlm[15:8] on the cycle after tx_done.
- TLM_M --tx_done--> TLM_L: pulse trmt with tx_data=tlm[7:0].
- TLM_L --tx_done--> IDLE: pulse tlm_sent.
- Responses arriving mid-frame wait in resp_hold and never interleave with frame bytes.
- tx_done is ignored in IDLE. A tx_done arriving in the same cycle as a trmt pulse is ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_arb_pkg:
  - state enum: IDLE, RESP, TLM_H, TLM_M, TLM_L;
  - constants RESP_DONE=8'hA5, RESP_BUSY=8'h5A, default TLM_HDR.
- One natural sub-module: arb_hold_reg.
  - Parameterised width; valid bit; overwrite-detect output.
  - Instantiated twice, once for the response path and once for the telemetry path.

Test Plan:
- Reset, then send_resp with resp=8'hA5:
  - trmt pulses one cycle later with tx_data=A5;
  - tx_done 20 cycles later -> resp_sent pulse, busy falls.
- tlm_req with tlm_data=16'h1234:
  - bytes C3, 12, 34 are issued in order, each trmt one cycle after the prior tx_done;
  - tlm_sent pulses exactly once, after the third tx_done.
- send_resp=8'h5A issued during the TLM_M byte:
  - 5A is not transmitted until after tlm_sent;
  - frame bytes are uninterrupted.
- tlm_v held pending while 6 back-to-back responses are requested (STARVE_MAX=4):
  - 4 responses are sent, then the telemetry frame, then the remaining 2 responses.
- Two send_resp pulses (A5 then 5A) while the block is busy with a frame:
  - only 5A is transmitted; drop_cnt reads 1.
  - 20 overwrites -> drop_cnt saturates at 15.
- rst asserted during TLM_M:
  - next cycle: state IDLE, trmt/tx_data/drop_cnt=0, no tlm_sent;
  - a later tx_done is ignored.
